// File: rtl/load_store_unit_if.sv
// Word-wide data RAM port between the load/store unit (master) and memory (slave).
// Request fields are held stable by the master for as long as mem_req is high.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS LB/LBU/LH/LHU/LW/SB/SH/SW memory stage: byte-lane steering, load extension,
// misalignment trap and a bus timeout over a req/ack word RAM port.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_addr_err,
  output logic              o_bus_err,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ERR,
    S_DONE
  } state_e;

  state_e           r_state;
  op_e              r_op;
  logic [1:0]       r_lane;
  logic [CNT_W-1:0] r_cnt;

  op_e              w_op;
  logic             w_store;
  logic             w_half;
  logic             w_word;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [15:0]      w_lane_data;
  logic [31:0]      w_load;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  assign w_op = op_e'(i_op);

  always_comb begin
    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    w_store = 1'b0;
    w_half  = 1'b0;
    w_word  = 1'b0;
    w_be    = 4'b0001 << i_addr[1:0];
    w_wdata = {4{i_wdata[7:0]}};
    case (w_op)
      OP_SB: w_store = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        w_half  = 1'b1;
        w_store = (w_op == OP_SH);
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      OP_LW, OP_SW: begin
        w_word  = 1'b1;
        w_store = (w_op == OP_SW);
        w_be    = 4'b1111;
        w_wdata = i_wdata;
      end
      default: ;
    endcase
  end

  assign w_misaligned = (w_half & i_addr[0]) | (w_word & (|i_addr[1:0]));

  // Lane shift uses the byte offset captured at accept time, not the live address.
  assign w_lane_data = 16'(bus.mem_rdata >> {r_lane, 3'b000});

  always_comb begin
    w_load = bus.mem_rdata;
    case (r_op)
      OP_LB:  w_load = {{24{w_lane_data[7]}}, w_lane_data[7:0]};
      OP_LBU: w_load = {24'h0, w_lane_data[7:0]};
      OP_LH:  w_load = {{16{w_lane_data[15]}}, w_lane_data[15:0]};
      OP_LHU: w_load = {16'h0, w_lane_data[15:0]};
      default: ;
    endcase
  end

  // The counter holds the number of REQ cycles already elapsed; the timeout fires on
  // the edge that ends the TIMEOUT-th cycle with mem_req high.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_LB;
      r_lane        <= 2'b00;
      r_cnt         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rdata       <= 32'h0;
      o_addr_err    <= 1'b0;
      o_bus_err     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else begin
      o_done     <= 1'b0;
      o_addr_err <= 1'b0;
      o_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op   <= w_op;
            r_lane <= i_addr[1:0];
            o_busy <= 1'b1;
            if (w_misaligned) begin
              r_state    <= S_ERR;
              o_done     <= 1'b1;
              o_addr_err <= 1'b1;
            end else begin
              r_state       <= S_REQ;
              r_cnt         <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= w_store;
              bus.mem_be    <= w_be;
              bus.mem_addr  <= {i_addr[31:2], 2'b00};
              bus.mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            r_state     <= S_DONE;
            bus.mem_req <= 1'b0;
            o_done      <= 1'b1;
            if (!bus.mem_we) begin
              o_rdata <= w_load;
            end
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            bus.mem_req <= 1'b0;
            o_done      <= 1'b1;
            o_bus_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_ERR, S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
